// File: rtl/dict_boot_loader.sv
// -----------------------------------------------------------------------------
// dict_boot_loader
//
// Boot-time loader that sits between main memory and the compression
// controller. After reset it walks a fixed dictionary image in memory, one
// 32-bit word per entry, and replays the entries onto three dictionary write
// ports in key order. Once the last region is finished it raises load_done
// and hands the memory port over to the controller. Until then the
// controller's requests are stalled.
//
// Image layout (word index W, byte address = DICT_BASE_ADDR + 4*W):
//   dict1 : W = 0 .. 2**FIELD1_KEY_WIDTH-1
//   dict2 : next 2**FIELD2_KEY_WIDTH words
//   dict3 : next 2**FIELD3_KEY_WIDTH words
//   bit 31 set = terminator (region ends, word is not written)
//
// Handshake: a request is presented by mem_req_valid/mem_req_addr and both
// are held stable until mem_req_ready is seen high; the data on
// mem_req_rdata is taken in that same cycle and the request is complete.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   mem_req_valid/addr (out)   read request to memory
//   mem_req_ready/rdata (in)   memory response, data valid when ready
//   ctrl_mem_req_valid/addr    controller request, honoured only after load
//   ctrl_mem_req_ready (out)   mem_req_ready once loaded, 0 before
//   ctrl_mem_req_rdata (out)   mem_req_rdata, always passed through
//   dictN_write_enable/val     one-cycle write pulse per dictionary entry
//   load_done (out)            image fully loaded, sticky until reset
//   dbg_state (out)            {region state, word phase} for observation
// -----------------------------------------------------------------------------
module dict_boot_loader #(
    parameter int          FIELD1_KEY_WIDTH = 3,
    parameter int          FIELD2_KEY_WIDTH = 5,
    parameter int          FIELD3_KEY_WIDTH = 8,
    parameter int          FIELD1_VAL_WIDTH = 7,
    parameter int          FIELD2_VAL_WIDTH = 10,
    parameter int          FIELD3_VAL_WIDTH = 15,
    parameter logic [31:0] DICT_BASE_ADDR   = 32'h0001_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_addr,
    input  logic [31:0]                 mem_req_rdata,
    input  logic                        ctrl_mem_req_valid,
    output logic                        ctrl_mem_req_ready,
    input  logic [31:0]                 ctrl_mem_req_addr,
    output logic [31:0]                 ctrl_mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        load_done,
    output logic [3:0]                  dbg_state
);

    localparam int D1_SIZE = 1 << FIELD1_KEY_WIDTH;
    localparam int D2_SIZE = 1 << FIELD2_KEY_WIDTH;
    localparam int D3_SIZE = 1 << FIELD3_KEY_WIDTH;
    localparam int TOTAL   = D1_SIZE + D2_SIZE + D3_SIZE;
    localparam int WW      = $clog2(TOTAL);

    localparam logic [WW-1:0] D1_LAST  = WW'(D1_SIZE - 1);
    localparam logic [WW-1:0] D2_FIRST = WW'(D1_SIZE);
    localparam logic [WW-1:0] D2_LAST  = WW'(D1_SIZE + D2_SIZE - 1);
    localparam logic [WW-1:0] D3_FIRST = WW'(D1_SIZE + D2_SIZE);
    localparam logic [WW-1:0] D3_LAST  = WW'(TOTAL - 1);

    typedef enum logic [1:0] {
        LOAD1 = 2'd0,
        LOAD2 = 2'd1,
        LOAD3 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Each word walks ISSUE -> WAIT -> WRITE, giving 3 cycles per word with
    // 0-wait memory: request register set, handshake, write pulse.
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_WRITE = 2'd2
    } phase_t;

    state_t                      r_state, w_state_nxt;
    phase_t                      r_phase, w_phase_nxt;
    logic [WW-1:0]               r_w, w_w_nxt;
    logic                        r_req_valid, w_req_valid_nxt;
    logic [31:0]                 r_req_addr, w_req_addr_nxt;
    logic                        r_term, w_term_nxt;
    logic                        r_we1, w_we1_nxt;
    logic                        r_we2, w_we2_nxt;
    logic                        r_we3, w_we3_nxt;
    logic [FIELD1_VAL_WIDTH-1:0] r_val1, w_val1_nxt;
    logic [FIELD2_VAL_WIDTH-1:0] r_val2, w_val2_nxt;
    logic [FIELD3_VAL_WIDTH-1:0] r_val3, w_val3_nxt;
    logic                        r_load_done, w_load_done_nxt;

    logic [31:0]                 w_word_off;
    logic                        w_is_term;

    assign w_word_off = {{(30-WW){1'b0}}, r_w, 2'b00};
    assign w_is_term  = mem_req_rdata[31];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LOAD1;
            r_phase     <= PH_ISSUE;
            r_w         <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= DICT_BASE_ADDR;
            r_term      <= 1'b0;
            r_we1       <= 1'b0;
            r_we2       <= 1'b0;
            r_we3       <= 1'b0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_val3      <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_w         <= w_w_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_term      <= w_term_nxt;
            r_we1       <= w_we1_nxt;
            r_we2       <= w_we2_nxt;
            r_we3       <= w_we3_nxt;
            r_val1      <= w_val1_nxt;
            r_val2      <= w_val2_nxt;
            r_val3      <= w_val3_nxt;
            r_load_done <= w_load_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_w_nxt         = r_w;
        w_req_valid_nxt = r_req_valid;
        w_req_addr_nxt  = r_req_addr;
        w_term_nxt      = r_term;
        w_we1_nxt       = 1'b0;
        w_we2_nxt       = 1'b0;
        w_we3_nxt       = 1'b0;
        w_val1_nxt      = r_val1;
        w_val2_nxt      = r_val2;
        w_val3_nxt      = r_val3;
        w_load_done_nxt = r_load_done;

        if (r_state != DONE) begin
            case (r_phase)
                PH_ISSUE: begin
                    w_req_valid_nxt = 1'b1;
                    w_req_addr_nxt  = DICT_BASE_ADDR + w_word_off;
                    w_phase_nxt     = PH_WAIT;
                end
                PH_WAIT: begin
                    // Valid/address stay put until memory answers.
                    if (mem_req_ready) begin
                        w_req_valid_nxt = 1'b0;
                        w_term_nxt      = w_is_term;
                        w_phase_nxt     = PH_WRITE;
                        if (!w_is_term) begin
                            case (r_state)
                                LOAD1: begin
                                    w_we1_nxt  = 1'b1;
                                    w_val1_nxt = mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                                end
                                LOAD2: begin
                                    w_we2_nxt  = 1'b1;
                                    w_val2_nxt = mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                                end
                                LOAD3: begin
                                    w_we3_nxt  = 1'b1;
                                    w_val3_nxt = mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PH_WRITE: begin
                    // Pulse is on the outputs this cycle; pick the next word.
                    w_phase_nxt = PH_ISSUE;
                    case (r_state)
                        LOAD1: begin
                            if (r_term || (r_w == D1_LAST)) begin
                                w_w_nxt     = D2_FIRST;
                                w_state_nxt = LOAD2;
                            end else begin
                                w_w_nxt = r_w + WW'(1);
                            end
                        end
                        LOAD2: begin
                            if (r_term || (r_w == D2_LAST)) begin
                                w_w_nxt     = D3_FIRST;
                                w_state_nxt = LOAD3;
                            end else begin
                                w_w_nxt = r_w + WW'(1);
                            end
                        end
                        LOAD3: begin
                            if (r_term || (r_w == D3_LAST)) begin
                                w_state_nxt     = DONE;
                                w_load_done_nxt = 1'b1;
                            end else begin
                                w_w_nxt = r_w + WW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                default: w_phase_nxt = PH_ISSUE;
            endcase
        end
    end

    // Once loaded, the controller owns the memory port combinationally.
    assign mem_req_valid      = (r_state == DONE) ? ctrl_mem_req_valid : r_req_valid;
    assign mem_req_addr       = (r_state == DONE) ? ctrl_mem_req_addr  : r_req_addr;
    assign ctrl_mem_req_ready = (r_state == DONE) & mem_req_ready;
    assign ctrl_mem_req_rdata = mem_req_rdata;

    assign dict1_write_enable = r_we1;
    assign dict1_write_val    = r_val1;
    assign dict2_write_enable = r_we2;
    assign dict2_write_val    = r_val2;
    assign dict3_write_enable = r_we3;
    assign dict3_write_val    = r_val3;
    assign load_done          = r_load_done;
    assign dbg_state          = {r_state, r_phase};

endmodule

// File: tb/tb_dict_boot_loader.sv
// Bench for dict_boot_loader: memory model answering loader reads from an
// image array, expected address and write queues filled per scenario, and a
// negedge monitor that pops and compares as the DUT produces them.
module tb_dict_boot_loader;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int NWORDS = 296;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata = 32'h0;
  logic        ctrl_mem_req_valid = 1'b0;
  logic        ctrl_mem_req_ready;
  logic [31:0] ctrl_mem_req_addr = 32'h0;
  logic [31:0] ctrl_mem_req_rdata;
  logic        dict1_write_enable;
  logic [6:0]  dict1_write_val;
  logic        dict2_write_enable;
  logic [9:0]  dict2_write_val;
  logic        dict3_write_enable;
  logic [14:0] dict3_write_val;
  logic        load_done;
  logic [3:0]  dbg_state;

  dict_boot_loader dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rdata      (mem_req_rdata),
    .ctrl_mem_req_valid (ctrl_mem_req_valid),
    .ctrl_mem_req_ready (ctrl_mem_req_ready),
    .ctrl_mem_req_addr  (ctrl_mem_req_addr),
    .ctrl_mem_req_rdata (ctrl_mem_req_rdata),
    .dict1_write_enable (dict1_write_enable),
    .dict1_write_val    (dict1_write_val),
    .dict2_write_enable (dict2_write_enable),
    .dict2_write_val    (dict2_write_val),
    .dict3_write_enable (dict3_write_enable),
    .dict3_write_val    (dict3_write_val),
    .load_done          (load_done),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] img [NWORDS];
  logic [31:0] exp_addr_q[$];
  logic [16:0] exp_q[$];      // {dict id, value zero-extended to 15 bits}
  int checks = 0;
  int failures = 0;
  int n1, n2, n3;             // observed pulses per dictionary
  int e1, e2, e3;             // expected pulses per dictionary
  int lat_mode = 0;           // 0: zero-wait, 1: random 0..7 wait
  bit resp_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Build image for a scenario and the expected request/write streams.
  task automatic prep(input int scen);
    int base [3];
    int size [3];
    int w;
    logic [16:0] ent;
    base = '{0, 8, 40};
    size = '{8, 32, 256};
    exp_addr_q.delete();
    exp_q.delete();
    n1 = 0; n2 = 0; n3 = 0;
    e1 = 0; e2 = 0; e3 = 0;
    for (int i = 0; i < NWORDS; i++)
      img[i] = (32'(i) * 32'h0001_3579 + 32'h0000_2468) & 32'h7FFF_FFFF;
    if (scen == 2) img[3] = 32'h8000_0000;
    if (scen == 3) begin
      img[8]  = 32'h8000_0000;
      img[40] = 32'h8000_0000;
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < size[r]; k++) begin
        w = base[r] + k;
        exp_addr_q.push_back(BASE + 32'(4 * w));
        if (img[w][31]) break;
        case (r)
          0: begin ent = {2'd1, 8'd0, img[w][6:0]};  e1++; end
          1: begin ent = {2'd2, 5'd0, img[w][9:0]};  e2++; end
          default: begin ent = {2'd3, img[w][14:0]}; e3++; end
        endcase
        exp_q.push_back(ent);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rst_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_rst_addr"},  64'(mem_req_addr), 64'(BASE));
    chk({tag, "_rst_we"},    64'({dict1_write_enable, dict2_write_enable, dict3_write_enable}), 64'd0);
    chk({tag, "_rst_val1"},  64'(dict1_write_val), 64'd0);
    chk({tag, "_rst_val2"},  64'(dict2_write_val), 64'd0);
    chk({tag, "_rst_val3"},  64'(dict3_write_val), 64'd0);
    chk({tag, "_rst_done"},  64'(load_done), 64'd0);
    chk({tag, "_rst_cready"}, 64'(ctrl_mem_req_ready), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Waits (bounded) for load_done, then checks cycle count and stream ends.
  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!load_done && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    if (exp_cyc > 0) chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    repeat (4) @(negedge clk);
    chk({tag, "_wr_left"},   64'(exp_q.size()), 64'd0);
    chk({tag, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({tag, "_n1"}, 64'(n1), 64'(e1));
    chk({tag, "_n2"}, 64'(n2), 64'(e2));
    chk({tag, "_n3"}, 64'(n3), 64'(e3));
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int cnt = -1;
    int idx;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        cnt = -1;
      end else if (reset || load_done) begin
        mem_req_ready = 1'b0;
        cnt = -1;
      end else begin
        mem_req_ready = 1'b0;
        mem_req_rdata = 32'hDEAD_BEEF;
        if (mem_req_valid) begin
          if (cnt < 0) cnt = (lat_mode == 1) ? int'($urandom_range(0, 7)) : 0;
          if (cnt == 0) begin
            idx = int'((mem_req_addr - BASE) >> 2);
            mem_req_ready = 1'b1;
            mem_req_rdata = (idx >= 0 && idx < NWORDS) ? img[idx] : 32'hFFFF_FFFF;
            cnt = -1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        p_wait = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [31:0] ea;
    logic [16:0] ew;
    logic [16:0] got;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_wait = 1'b0;
      end else begin
        if (p_wait && !load_done) begin
          chk("hold_valid", 64'(mem_req_valid), 64'd1);
          chk("hold_addr",  64'(mem_req_addr), 64'(p_addr));
        end
        if (!load_done) chk("ctrl_stalled", 64'(ctrl_mem_req_ready), 64'd0);
        chk("rdata_pass", 64'(ctrl_mem_req_rdata), 64'(mem_req_rdata));
        if (!load_done && mem_req_valid && mem_req_ready) begin
          ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
          chk("req_addr", 64'(mem_req_addr), 64'(ea));
        end
        if (32'(dict1_write_enable) + 32'(dict2_write_enable) + 32'(dict3_write_enable) > 1)
          chk("onehot_we", 64'({dict1_write_enable, dict2_write_enable, dict3_write_enable}), 64'd0);
        if (dict1_write_enable || dict2_write_enable || dict3_write_enable) begin
          chk("we_in_done", 64'(load_done), 64'd0);
          if (dict1_write_enable) begin got = {2'd1, 8'd0, dict1_write_val}; n1++; end
          else if (dict2_write_enable) begin got = {2'd2, 5'd0, dict2_write_val}; n2++; end
          else begin got = {2'd3, dict3_write_val}; n3++; end
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
          chk("wr_entry", 64'(got), 64'(ew));
        end
        p_wait = mem_req_valid && !mem_req_ready && !load_done;
        p_addr = mem_req_addr;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #1;
    chk("t0_done", 64'(load_done), 64'd0);
    chk("t0_valid", 64'(mem_req_valid), 64'd0);

    // 1: full image, zero-wait
    prep(1);
    do_reset();
    wait_done("s1", 888);

    // 2: terminator at W=3
    prep(2);
    do_reset();
    wait_done("s2", 0);

    // 3: terminators at W=8 and W=40
    prep(3);
    do_reset();
    wait_done("s3", 30);

    // 4: random ready latency
    lat_mode = 1;
    prep(1);
    do_reset();
    wait_done("s4", 0);
    lat_mode = 0;

    // 5: controller requesting during load, then forwarded after
    ctrl_mem_req_valid = 1'b1;
    ctrl_mem_req_addr  = 32'h0000_0040;
    prep(1);
    do_reset();
    wait_done("s5", 888);
    resp_en = 1'b0;
    @(posedge clk);
    #2;
    mem_req_ready = 1'b1;
    mem_req_rdata = 32'hCAFE_0040;
    #1;
    chk("s5_fwd_valid", 64'(mem_req_valid), 64'd1);
    chk("s5_fwd_addr",  64'(mem_req_addr), 64'h40);
    chk("s5_fwd_ready", 64'(ctrl_mem_req_ready), 64'd1);
    chk("s5_fwd_rdata", 64'(ctrl_mem_req_rdata), 64'hCAFE_0040);
    mem_req_ready = 1'b0;
    #1;
    chk("s5_fwd_ready0", 64'(ctrl_mem_req_ready), 64'd0);
    ctrl_mem_req_valid = 1'b0;
    #1;
    chk("s5_fwd_valid0", 64'(mem_req_valid), 64'd0);
    repeat (3) @(posedge clk);
    resp_en = 1'b1;

    // 6: reset in the middle of dict2 (W=20), then full reload
    prep(1);
    do_reset();
    n = 0;
    while (!(mem_req_valid && mem_req_ready && mem_req_addr == BASE + 32'd80) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("s6_reached_w20", 64'(n < 2000), 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("s6_mid");
    prep(1);
    do_reset();
    chk("s6_first_addr", 64'(mem_req_addr), 64'(BASE));
    wait_done("s6", 888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
